// File: rtl/qtcore_multi_scan_bridge_if.sv
// qtcore_multi_scan_bridge_if: pin-side and core-side signals of the scan bridge
interface qtcore_multi_scan_bridge_if #(
  parameter int NUM_CORES = 2,
  parameter int LED_W = 7
);
  logic scan_cs_n, proc_en_n, scan_in, btn_in, miso, core_scan_in, core_btn;
  logic [NUM_CORES-1:0] core_scan_out, core_halt, core_scan_en, core_proc_en;
  logic [NUM_CORES*LED_W-1:0] core_led;
  logic [LED_W-1:0] led_out;
  modport master (
    output scan_cs_n, proc_en_n, scan_in, btn_in, core_scan_out, core_halt, core_led,
    input miso, led_out, core_scan_en, core_scan_in, core_proc_en, core_btn
  );
  modport slave (
    input scan_cs_n, proc_en_n, scan_in, btn_in, core_scan_out, core_halt, core_led,
    output miso, led_out, core_scan_en, core_scan_in, core_proc_en, core_btn
  );
endinterface

// File: rtl/qtcore_multi_scan_bridge.sv
// qtcore_multi_scan_bridge: routes one SPI-style pin set to NUM_CORES scan chains,
// arbitrates proc enable, debounces the button and muxes the addressed core's LEDs.
module qtcore_multi_scan_bridge #(
  parameter int NUM_CORES = 2,
  parameter int LED_W = 7,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input logic clk,
  input logic rst,
  qtcore_multi_scan_bridge_if.slave bus
);
  localparam int ADDR_W = NUM_CORES > 1 ? $clog2(NUM_CORES) : 1;
  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  typedef enum logic [1:0] {IDLE, ADDR, STREAM, NUL} state_e;
  state_e state;
  logic [2:0] bit_cnt;
  logic [ADDR_W-1:0] addr_sr, sel, led_sel, addr_nxt;
  logic addr_ok, stream, proc, btn_s1, btn_s2;
  logic [DB_W-1:0] db_cnt;
  always_comb begin
    addr_nxt = ADDR_W'({addr_sr, bus.scan_in});
    addr_ok = {1'b0, addr_nxt} < (ADDR_W+1)'(NUM_CORES);
  end
  // Header bits are consumed in IDLE too, so a 1-bit address completes on the first edge
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      bit_cnt <= '0;
      addr_sr <= '0;
      sel <= '0;
      led_sel <= '0;
    end else if (bus.scan_cs_n) begin
      state <= IDLE;
      bit_cnt <= '0;
    end else if (state == IDLE || state == ADDR) begin
      addr_sr <= addr_nxt;
      bit_cnt <= bit_cnt + 3'd1;
      if (bit_cnt == 3'(ADDR_W - 1)) begin
        sel <= addr_nxt;
        state <= addr_ok ? STREAM : NUL;
        if (addr_ok) led_sel <= addr_nxt;
      end else begin
        state <= ADDR;
      end
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      btn_s1 <= 1'b0;
      btn_s2 <= 1'b0;
      db_cnt <= '0;
      bus.core_btn <= 1'b0;
    end else begin
      btn_s1 <= bus.btn_in;
      btn_s2 <= btn_s1;
      if (btn_s2 == bus.core_btn) db_cnt <= '0;
      else if (db_cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
        bus.core_btn <= btn_s2;
        db_cnt <= '0;
      end else db_cnt <= db_cnt + DB_W'(1);
    end
  end
  // Scan wins over proc; proc is also held off while reset is asserted
  always_comb begin
    stream = state == STREAM && !bus.scan_cs_n;
    proc = rst && bus.scan_cs_n && !bus.proc_en_n;
    bus.core_scan_en = stream ? NUM_CORES'(1) << sel : '0;
    bus.core_proc_en = {NUM_CORES{proc}};
    bus.miso = stream ? bus.core_scan_out[sel] : proc & (&bus.core_halt);
    bus.core_scan_in = bus.scan_in;
    bus.led_out = bus.core_led[LED_W*int'(led_sel) +: LED_W];
  end
endmodule
